// File: rtl/thumb_fetch_align_if.sv
// Fetch/decode bundle for the Thumb halfword aligner.
// DUT takes the slave side; memory and decode sit behind master.
interface thumb_fetch_align_if;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ack;
  logic [31:0] fetch_data;
  logic        flush;
  logic [31:0] flush_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_inst;
  logic        dec_inst_16;
  logic [31:0] dec_pc;

  modport slave (
    output fetch_req, fetch_addr,
    input  fetch_ack, fetch_data,
    input  flush, flush_pc,
    output dec_valid, dec_inst,
    output dec_inst_16, dec_pc,
    input  dec_ready
  );

  modport master (
    input  fetch_req, fetch_addr,
    output fetch_ack, fetch_data,
    output flush, flush_pc,
    input  dec_valid, dec_inst,
    input  dec_inst_16, dec_pc,
    output dec_ready
  );
endinterface

// File: rtl/thumb_fetch_align.sv
// Halfword fetch queue and 16/32-bit Thumb aligner.
// Word fetches in, one instruction per cycle out to decode.
module thumb_fetch_align #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                 clk,
  input logic                 rst,
  thumb_fetch_align_if.slave  io_bus
);
  logic [15:0] r_q [4];
  logic [2:0]  r_cnt;
  logic [29:0] r_faddr;
  logic [30:0] r_pc;
  logic        r_skip;

  logic [15:0] w_hw0;
  logic [15:0] w_hw1;
  logic        w_pre;
  logic        w_valid;
  logic        w_xfer;
  logic        w_req;
  logic        w_push;
  logic [2:0]  w_npop;
  logic [2:0]  w_cnt_ap;
  logic [2:0]  w_cnt_nx;
  logic [15:0] w_sh [4];
  logic [15:0] w_q_nx [4];
  logic        w_unused;

  assign w_unused = io_bus.flush_pc[0];

  assign w_hw0 = r_q[0];
  assign w_hw1 = r_q[1];

  // 32-bit prefixes are 0b11101, 0b11110, 0b11111 in [15:11]
  assign w_pre = (w_hw0[15:13] == 3'b111)
               & (w_hw0[12:11] != 2'b00);

  assign w_valid = ~rst & ~io_bus.flush
                 & (w_pre ? (r_cnt >= 3'd2)
                          : (r_cnt != 3'd0));

  assign w_xfer = w_valid & io_bus.dec_ready;

  assign w_npop = !w_xfer ? 3'd0 :
                  w_pre   ? 3'd2 : 3'd1;

  assign w_cnt_ap = r_cnt - w_npop;

  assign w_req = ~rst & ~io_bus.flush
               & (w_cnt_ap <= 3'd2);

  assign w_push = w_req & io_bus.fetch_ack;

  assign w_cnt_nx = w_cnt_ap
                  + (!w_push ? 3'd0 :
                     r_skip  ? 3'd1 : 3'd2);

  always_comb begin
    w_sh[0] = w_npop[1] ? r_q[2] :
              w_npop[0] ? r_q[1] : r_q[0];
    w_sh[1] = w_npop[1] ? r_q[3] :
              w_npop[0] ? r_q[2] : r_q[1];
    w_sh[2] = w_npop[1] ? 16'h0000 :
              w_npop[0] ? r_q[3] : r_q[2];
    w_sh[3] = (w_npop != 3'd0) ? 16'h0000 : r_q[3];
  end

  // Push lands directly behind whatever survives the pop
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_q_nx[i] = w_sh[i];
      if (w_push) begin
        if (3'(i) == w_cnt_ap) begin
          w_q_nx[i] = r_skip ? io_bus.fetch_data[31:16]
                             : io_bus.fetch_data[15:0];
        end else if (!r_skip &&
                     3'(i) == w_cnt_ap + 3'd1) begin
          w_q_nx[i] = io_bus.fetch_data[31:16];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= 3'd0;
      r_faddr <= RESET_PC[31:2];
      r_pc    <= RESET_PC[31:1];
      r_skip  <= RESET_PC[1];
    end else if (io_bus.flush) begin
      r_cnt   <= 3'd0;
      r_faddr <= io_bus.flush_pc[31:2];
      r_pc    <= io_bus.flush_pc[31:1];
      r_skip  <= io_bus.flush_pc[1];
    end else begin
      r_cnt <= w_cnt_nx;
      for (int i = 0; i < 4; i++) begin
        r_q[i] <= w_q_nx[i];
      end
      if (w_xfer) begin
        r_pc <= r_pc + (w_pre ? 31'd2 : 31'd1);
      end
      if (w_push) begin
        r_faddr <= r_faddr + 30'd1;
        r_skip  <= 1'b0;
      end
    end
  end

  assign io_bus.fetch_req   = w_req;
  assign io_bus.fetch_addr  = {r_faddr, 2'b00};
  assign io_bus.dec_valid   = w_valid;
  assign io_bus.dec_inst    = !w_valid ? 32'h0 :
                              w_pre    ? {w_hw0, w_hw1} :
                                         {w_hw0, 16'h0000};
  assign io_bus.dec_inst_16 = w_valid & ~w_pre;
  assign io_bus.dec_pc      = {r_pc, 1'b0};
endmodule

// File: tb/tb_thumb_fetch_align.sv
// Self-checking bench for thumb_fetch_align.
// Sparse random halfword memory plus an instruction-stream model.
module tb_thumb_fetch_align;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  thumb_fetch_align_if bus ();

  thumb_fetch_align #(.RESET_PC(32'h100)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] hmem [logic [31:0]];
  logic [31:0] epc;
  logic [31:0] fend;

  function automatic logic [15:0] get_hw(input logic [31:0] a);
    logic [15:0] v;
    if (!hmem.exists(a)) begin
      v = 16'($urandom);
      if ($urandom_range(9) < 3)
        v[15:11] = 5'd29 + 5'($urandom_range(2));
      hmem[a] = v;
    end
    return hmem[a];
  endfunction

  function automatic logic is_pre(input logic [15:0] h);
    return h[15:11] inside {5'b11101, 5'b11110, 5'b11111};
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {get_hw(a + 32'd2), get_hw(a)};
  endfunction

  task automatic drive(input logic ack, input logic rdy,
                       input logic fl, input logic [31:0] fpc);
    @(posedge clk); #1;
    bus.fetch_ack  = ack;
    bus.dec_ready  = rdy;
    bus.flush      = fl;
    bus.flush_pc   = fpc;
    bus.fetch_data = mem_word(bus.fetch_addr);
    #3;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.fetch_ack = 1'b0;
    bus.flush = 1'b0;
    bus.dec_ready = 1'b0;
    #3;
    checks++;
    if (bus.fetch_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_req got=%b exp=0", bus.fetch_req);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #3;
    checks++;
    if (bus.fetch_req !== 1'b1) begin
      errors++;
      $display("FAIL post_rst_req got=%b exp=1", bus.fetch_req);
    end
    checks++;
    if (bus.fetch_addr !== 32'h100) begin
      errors++;
      $display("FAIL rst_faddr got=%h exp=100", bus.fetch_addr);
    end
    checks++;
    if (bus.dec_pc !== 32'h100) begin
      errors++;
      $display("FAIL rst_pc got=%h exp=100", bus.dec_pc);
    end
    checks++;
    if ({bus.dec_valid, bus.dec_inst_16, bus.dec_inst} !== 34'h0) begin
      errors++;
      $display("FAIL rst_dec got=%b%b_%h exp=0", bus.dec_valid,
               bus.dec_inst_16, bus.dec_inst);
    end
  endtask

  task automatic test_basic();
    logic [15:0] exp [4];
    int got;
    exp = '{16'h4608, 16'h2001, 16'hBF00, 16'h4770};
    for (int i = 0; i < 4; i++) hmem[32'h100 + 2 * i] = exp[i];
    got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      if (bus.dec_valid) begin
        checks++;
        if (bus.dec_inst !== {exp[got], 16'h0} ||
            bus.dec_pc !== 32'h100 + 32'(2 * got) ||
            bus.dec_inst_16 !== 1'b1) begin
          errors++;
          $display("FAIL basic_%0d got=%h/%h/%b exp=%h/%h/1", got,
                   bus.dec_inst, bus.dec_pc, bus.dec_inst_16,
                   {exp[got], 16'h0}, 32'h100 + 32'(2 * got));
        end
        got++;
      end
    end
    checks++;
    if (got != 4) begin
      errors++;
      $display("FAIL basic_count got=%0d exp=4", got);
    end
  endtask

  task automatic test_straddle();
    hmem[32'h200] = 16'h4608;
    hmem[32'h202] = 16'hF000;
    hmem[32'h204] = 16'hF800;
    hmem[32'h206] = 16'h4770;
    drive(1'b0, 1'b0, 1'b1, 32'h200);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    checks++;
    if (bus.fetch_addr !== 32'h200 || bus.fetch_req !== 1'b1) begin
      errors++;
      $display("FAIL strad_fetch got=%h/%b exp=200/1",
               bus.fetch_addr, bus.fetch_req);
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (bus.dec_valid !== 1'b1 || bus.dec_inst !== 32'h4608_0000 ||
        bus.dec_pc !== 32'h200) begin
      errors++;
      $display("FAIL strad_first got=%b/%h/%h exp=1/46080000/200",
               bus.dec_valid, bus.dec_inst, bus.dec_pc);
    end
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      checks++;
      if (bus.dec_valid !== 1'b0 || bus.dec_inst !== 32'h0) begin
        errors++;
        $display("FAIL strad_wait got=%b/%h exp=0/0",
                 bus.dec_valid, bus.dec_inst);
      end
    end
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if (bus.dec_valid !== 1'b0) begin
      errors++;
      $display("FAIL strad_ackcyc got=%b exp=0", bus.dec_valid);
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (bus.dec_valid !== 1'b1 || bus.dec_inst !== 32'hF000_F800 ||
        bus.dec_inst_16 !== 1'b0 || bus.dec_pc !== 32'h202) begin
      errors++;
      $display("FAIL strad_32 got=%b/%h/%b/%h exp=1/f000f800/0/202",
               bus.dec_valid, bus.dec_inst, bus.dec_inst_16, bus.dec_pc);
    end
  endtask

  task automatic test_flush_half();
    drive(1'b0, 1'b0, 1'b1, 32'h402);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    hmem[32'h300] = 16'hBBBB;
    hmem[32'h302] = 16'hAAAA;
    drive(1'b1, 1'b1, 1'b1, 32'h302);
    checks++;
    if (bus.dec_valid !== 1'b0 || bus.fetch_req !== 1'b0) begin
      errors++;
      $display("FAIL flush_cyc got=%b/%b exp=0/0",
               bus.dec_valid, bus.fetch_req);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (bus.fetch_addr !== 32'h300 || bus.dec_pc !== 32'h302 ||
        bus.dec_valid !== 1'b0 || bus.fetch_req !== 1'b1) begin
      errors++;
      $display("FAIL flush_next got=%h/%h/%b/%b exp=300/302/0/1",
               bus.fetch_addr, bus.dec_pc, bus.dec_valid, bus.fetch_req);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (bus.dec_valid !== 1'b1 || bus.dec_inst !== 32'hAAAA_0000 ||
        bus.dec_pc !== 32'h302 || bus.dec_inst_16 !== 1'b1) begin
      errors++;
      $display("FAIL flush_half got=%b/%h/%h/%b exp=1/aaaa0000/302/1",
               bus.dec_valid, bus.dec_inst, bus.dec_pc, bus.dec_inst_16);
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (bus.dec_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_skip got=%b exp=0", bus.dec_valid);
    end
  endtask

  task automatic test_stream(input logic [31:0] spc, input int n,
                             input int stall, input int pr,
                             input int pa, input int pf);
    logic [15:0] h0;
    logic        pre, ev, ereq, rdy, ack, fl;
    logic [31:0] einst, fpc;
    int          cnt, need, pop;
    drive(1'b0, 1'b0, 1'b1, spc);
    epc  = {spc[31:1], 1'b0};
    fend = epc;
    for (int c = 0; c < n; c++) begin
      rdy = (c < stall) ? 1'b0 : ($urandom_range(99) < pr);
      ack = (c < stall) ? 1'b1 : ($urandom_range(99) < pa);
      fl  = (c >= stall) && ($urandom_range(999) < pf);
      fpc = $urandom;
      drive(ack, rdy, fl, fpc);
      cnt   = int'((fend - epc) >> 1);
      h0    = get_hw(epc);
      pre   = is_pre(h0);
      need  = pre ? 2 : 1;
      ev    = !fl && cnt >= need;
      einst = !ev ? 32'h0 :
              pre ? {h0, get_hw(epc + 32'd2)} : {h0, 16'h0};
      pop   = (ev && rdy) ? need : 0;
      ereq  = !fl && (cnt - pop) <= 2;
      checks++;
      if (bus.dec_valid !== ev) begin
        errors++;
        $display("FAIL s_valid c=%0d got=%b exp=%b", c, bus.dec_valid, ev);
      end
      checks++;
      if (bus.dec_inst !== einst) begin
        errors++;
        $display("FAIL s_inst c=%0d got=%h exp=%h", c, bus.dec_inst, einst);
      end
      checks++;
      if (bus.dec_inst_16 !== (ev & ~pre)) begin
        errors++;
        $display("FAIL s_i16 c=%0d got=%b exp=%b", c,
                 bus.dec_inst_16, ev & ~pre);
      end
      checks++;
      if (bus.dec_pc !== epc) begin
        errors++;
        $display("FAIL s_pc c=%0d got=%h exp=%h", c, bus.dec_pc, epc);
      end
      checks++;
      if (bus.fetch_req !== ereq) begin
        errors++;
        $display("FAIL s_req c=%0d got=%b exp=%b", c, bus.fetch_req, ereq);
      end
      checks++;
      if (bus.fetch_addr !== {fend[31:2], 2'b00}) begin
        errors++;
        $display("FAIL s_faddr c=%0d got=%h exp=%h", c,
                 bus.fetch_addr, {fend[31:2], 2'b00});
      end
      if (fl) begin
        epc  = {fpc[31:1], 1'b0};
        fend = epc;
      end else begin
        epc = epc + 32'(2 * pop);
        if (ereq && ack) fend = {fend[31:2], 2'b00} + 32'd4;
      end
    end
  endtask

  task automatic test_reset_over_flush();
    for (int c = 0; c < 4; c++) drive(1'b1, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.flush = 1'b1;
    bus.flush_pc = 32'h500;
    bus.fetch_ack = 1'b1;
    bus.dec_ready = 1'b1;
    #3;
    checks++;
    if (bus.fetch_req !== 1'b0 || bus.dec_valid !== 1'b0) begin
      errors++;
      $display("FAIL rf_cyc got=%b/%b exp=0/0",
               bus.fetch_req, bus.dec_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.flush = 1'b0;
    bus.fetch_ack = 1'b0;
    #3;
    checks++;
    if (bus.fetch_addr !== 32'h100 || bus.dec_pc !== 32'h100 ||
        bus.dec_valid !== 1'b0 || bus.fetch_req !== 1'b1 ||
        bus.dec_inst !== 32'h0) begin
      errors++;
      $display("FAIL rf_state got=%h/%h/%b/%b/%h exp=100/100/0/1/0",
               bus.fetch_addr, bus.dec_pc, bus.dec_valid,
               bus.fetch_req, bus.dec_inst);
    end
    hmem[32'h100] = 16'h4608;
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (bus.dec_valid !== 1'b1 || bus.dec_inst !== 32'h4608_0000 ||
        bus.dec_pc !== 32'h100) begin
      errors++;
      $display("FAIL rf_first got=%b/%h/%h exp=1/46080000/100",
               bus.dec_valid, bus.dec_inst, bus.dec_pc);
    end
  endtask

  initial begin
    bus.fetch_ack  = 1'b0;
    bus.fetch_data = 32'h0;
    bus.flush      = 1'b0;
    bus.flush_pc   = 32'h0;
    bus.dec_ready  = 1'b0;
    test_reset();
    test_basic();
    test_straddle();
    test_flush_half();
    test_stream(32'h600, 40, 12, 100, 100, 0);
    test_stream(32'h1000, 400, 0, 100, 100, 0);
    test_stream(32'h2002, 400, 0, 60, 70, 20);
    test_stream(32'hFFFF_FFF8, 60, 0, 90, 90, 0);
    test_stream(32'h3000, 400, 0, 30, 40, 30);
    test_reset_over_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/thumb_fetch_align.md
# thumb_fetch_align

Halfword fetch buffer and aligner between instruction memory and the Thumb instruction class decoder. Requests 32-bit aligned words, queues up to four halfwords, splits the stream into 16-bit and 32-bit Thumb instructions, and hands one instruction per cycle to decode with its PC. Handles branch redirects, including redirects to halfword-aligned (PC[1]=1) targets.

## Interface
- RESET_PC, 32'h0000_0000, PC of first instruction after reset (bit 0 ignored)
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- fetch_req  out  1  word request to instruction memory
- fetch_addr  out  32  word address of request, bits [1:0] always 0
- fetch_ack  in  1  memory returns fetch_data this cycle; only valid while fetch_req=1
- fetch_data  in  32  little-endian word: [15:0] at fetch_addr, [31:16] at fetch_addr+2
- flush  in  1  redirect; highest priority
- flush_pc  in  32  redirect target (bit 0 ignored)
- dec_valid  out  1  instruction presented to decode
- dec_ready  in  1  decode accepts; transfer when dec_valid & dec_ready
- dec_inst  out  32  16-bit: {hw0,16'h0000}; 32-bit: {hw0,hw1}; opcode always in [31:26]
- dec_inst_16  out  1  1 = 16-bit instruction
- dec_pc  out  32  address of hw0

## Operation
- State: 4-entry halfword queue (hw0 = head), count 0..4, fetch_addr register, skip flag, dec_pc register.
- Width rule: head halfword is 32-bit prefix when hw0[15:11] is 5'b11101, 5'b11110 or 5'b11111; otherwise 16-bit.
- dec_valid = (count>=1 & head 16-bit) | (count>=2 & head 32-bit prefix). Combinational from registered queue only; no dependence on dec_ready.
- dec_inst_16 = ~prefix(hw0). Outputs undefined-but-stable content not required when dec_valid=0; drive zeros.
- Pop: on transfer, remove 1 (16-bit) or 2 (32-bit) halfwords; dec_pc += 2 or 4.
- fetch_req = ~rst & ~flush & (count_after_pop <= 2), where count_after_pop uses this cycle's transfer.
- Push on fetch_ack: append fetch_data[15:0] then [31:16]; if skip=1, append only [31:16] and clear skip. fetch_addr += 4.
- Simultaneous pop and push in one cycle: pop applied first, push appended behind remaining entries; count updates once.
- Flush: next cycle count=0, fetch_addr={flush_pc[31:2],2'b00}, dec_pc={flush_pc[31:1],1'b0}, skip=flush_pc[1]. fetch_ack and any transfer in the flush cycle are discarded (transfer not counted; decode must also discard).
- Reset: same as flush to RESET_PC. Reset dominates flush.
- Wrap-around: fetch_addr and dec_pc wrap modulo 2^32, no error.
- Never overflow: push only possible when post-pop count<=2, so count<=4 always.

## Timing
- Reset values: fetch_req=0 during rst, 1 the cycle after; fetch_addr={RESET_PC[31:2],2'b00}; dec_valid=0; dec_inst=0; dec_inst_16=0; dec_pc={RESET_PC[31:1],1'b0}; count=0; skip=RESET_PC[1].
- Latency: fetch_ack in cycle N -> instruction visible on dec_valid in N+1.
- Flush in cycle N: dec_valid=0 and fetch_req=0 in N; fetch_req=1 at new address in N+1; first instruction earliest N+2.
- 32-bit instruction straddling words: waits for second word; dec_valid low while count=1 with prefix head.
- Sustained throughput: one 16-bit or 32-bit instruction per cycle when memory acks every request and dec_ready=1 (16-bit stream: fetch_req drops every other cycle as queue fills).
- dec_ready=0: outputs hold stable; fetch continues until count>=3.

## Test plan
- Reset RESET_PC=0x100, ack words 0x2001_4608 then 0x4770_BF00 -> decode sees 0x4608 pc 0x100, 0x2001 pc 0x102, 0xBF00 pc 0x104, 0x4770 pc 0x106, all dec_inst_16=1, dec_inst[15:0]=0.
- 32-bit straddle: stream 16-bit 0x4608 at 0x200, then F000 F800 split across words -> dec_inst=0xF000_F800, dec_inst_16=0, dec_pc=0x202; dec_valid low until second word acked.
- Flush to 0x302 while queue holds 3 halfwords: next cycle count=0, fetch_addr=0x300; word 0xAAAA_BBBB acked -> only 0xAAAA issued, pc 0x302.
- Backpressure: dec_ready=0 for 10 cycles with memory always acking -> fetch_req drops once count>=3, outputs constant, no halfword lost or duplicated when dec_ready returns.
- Simultaneous pop of 32-bit instruction and push with count=2 -> count=2 next cycle, order preserved.
- rst asserted mid-stream with flush=1, flush_pc=0x500 -> state equals RESET_PC reset state, flush ignored.
